// File: rtl/rgb_to_ycrcb.sv
`timescale 1ns/1ps
// Three-stage RGB888 -> YCrCb (BT.601 full range) converter with a single global
// advance for valid/ready flow control; r/g/b and the sideband tag ride along aligned.
module rgb_to_ycrcb #(
    parameter int SIDEBAND_W = 22
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic [7:0]            r_in,
    input  logic [7:0]            g_in,
    input  logic [7:0]            b_in,
    input  logic [SIDEBAND_W-1:0] sideband_in,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic [7:0]            y_out,
    output logic [7:0]            cr_out,
    output logic [7:0]            cb_out,
    output logic [7:0]            r_out,
    output logic [7:0]            g_out,
    output logic [7:0]            b_out,
    output logic [SIDEBAND_W-1:0] sideband_out,
    output logic                  valid_out,
    input  logic                  ready_in
);

    // Coefficient index k = ch*3 + col, with ch 0=Y, 1=Cb, 2=Cr and col 0=R, 1=G, 2=B.
    // Magnitudes are stored unsigned; COEF_NEG marks the terms that are subtracted.
    localparam logic [8:0] COEF_NEG = 9'b110011000;

    function automatic logic [7:0] coef_mag(input int k);
        logic [7:0] m;
        case (k)
            0:       m = 8'd77;
            1:       m = 8'd150;
            2:       m = 8'd29;
            3:       m = 8'd43;
            4:       m = 8'd85;
            5:       m = 8'd128;
            6:       m = 8'd128;
            7:       m = 8'd107;
            8:       m = 8'd21;
            default: m = 8'd0;
        endcase
        return m;
    endfunction

    logic                  adv;
    logic [7:0]            pix_in [3];

    logic [15:0]           prod_next [9];
    logic [15:0]           prod1_reg [9];
    logic [7:0]            rgb1_reg  [3];
    logic [SIDEBAND_W-1:0] sb1_reg;
    logic                  valid1_reg;

    logic signed [17:0]    sum_next [3];
    logic signed [17:0]    sum2_reg [3];
    logic [7:0]            rgb2_reg [3];
    logic [SIDEBAND_W-1:0] sb2_reg;
    logic                  valid2_reg;

    logic [7:0]            chan_next [3];
    logic [7:0]            chan3_reg [3];
    logic [7:0]            rgb3_reg  [3];
    logic [SIDEBAND_W-1:0] sb3_reg;
    logic                  valid3_reg;

    // The whole pipeline moves as one; bubbles are carried, not squeezed.
    assign adv       = !valid3_reg || ready_in;
    assign ready_out = adv;

    assign pix_in[0] = r_in;
    assign pix_in[1] = g_in;
    assign pix_in[2] = b_in;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            for (genvar gj = 0; gj < 3; gj++) begin : g_prod
                assign prod_next[gi*3+gj] = {8'd0, pix_in[gj]} * {8'd0, coef_mag(gi*3+gj)};
            end

            logic signed [17:0] acc;
            always_comb begin
                acc = 18'sd128;
                for (int j = 0; j < 3; j++) begin
                    if (COEF_NEG[gi*3+j]) begin
                        acc = acc - $signed({2'b00, prod1_reg[gi*3+j]});
                    end else begin
                        acc = acc + $signed({2'b00, prod1_reg[gi*3+j]});
                    end
                end
            end
            assign sum_next[gi] = acc;

            // Chroma channels are re-centred on 128 after the floor shift.
            localparam logic signed [17:0] OFFSET = (gi == 0) ? 18'sd0 : 18'sd128;
            logic signed [17:0] shifted;
            assign shifted = (sum2_reg[gi] >>> 8) + OFFSET;
            assign chan_next[gi] = (shifted < 18'sd0)   ? 8'd0   :
                                   (shifted > 18'sd255) ? 8'd255 : shifted[7:0];
        end
    endgenerate

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid1_reg <= 1'b0;
            valid2_reg <= 1'b0;
            valid3_reg <= 1'b0;
            sb1_reg    <= '0;
            sb2_reg    <= '0;
            sb3_reg    <= '0;
            for (int k = 0; k < 9; k++) begin
                prod1_reg[k] <= '0;
            end
            for (int c = 0; c < 3; c++) begin
                rgb1_reg[c]  <= '0;
                rgb2_reg[c]  <= '0;
                rgb3_reg[c]  <= '0;
                sum2_reg[c]  <= '0;
                chan3_reg[c] <= '0;
            end
        end else if (adv) begin
            valid1_reg <= valid_in;
            valid2_reg <= valid1_reg;
            valid3_reg <= valid2_reg;
            sb1_reg    <= sideband_in;
            sb2_reg    <= sb1_reg;
            sb3_reg    <= sb2_reg;
            for (int k = 0; k < 9; k++) begin
                prod1_reg[k] <= prod_next[k];
            end
            for (int c = 0; c < 3; c++) begin
                rgb1_reg[c]  <= pix_in[c];
                rgb2_reg[c]  <= rgb1_reg[c];
                rgb3_reg[c]  <= rgb2_reg[c];
                sum2_reg[c]  <= sum_next[c];
                chan3_reg[c] <= chan_next[c];
            end
        end
    end

    assign y_out        = chan3_reg[0];
    assign cb_out       = chan3_reg[1];
    assign cr_out       = chan3_reg[2];
    assign r_out        = rgb3_reg[0];
    assign g_out        = rgb3_reg[1];
    assign b_out        = rgb3_reg[2];
    assign sideband_out = sb3_reg;
    assign valid_out    = valid3_reg;

endmodule

// File: tb/tb_rgb_to_ycrcb.sv
`timescale 1ns/1ps
// Directed and table-driven bench for rgb_to_ycrcb with a scoreboard of expected pixels.
module tb_rgb_to_ycrcb;

    localparam int SBW = 22;

    logic           clk = 1'b0;
    logic           rst_n_in;
    logic [7:0]     r_in, g_in, b_in;
    logic [SBW-1:0] sideband_in;
    logic           valid_in;
    logic           ready_out;
    logic [7:0]     y_out, cr_out, cb_out, r_out, g_out, b_out;
    logic [SBW-1:0] sideband_out;
    logic           valid_out;
    logic           ready_in;

    always #5 clk = ~clk;

    rgb_to_ycrcb #(.SIDEBAND_W(SBW)) dut (
        .clk_in(clk), .rst_n_in(rst_n_in),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .sideband_in(sideband_in), .valid_in(valid_in), .ready_out(ready_out),
        .y_out(y_out), .cr_out(cr_out), .cb_out(cb_out),
        .r_out(r_out), .g_out(g_out), .b_out(b_out),
        .sideband_out(sideband_out), .valid_out(valid_out), .ready_in(ready_in)
    );

    typedef struct {
        logic [7:0]     y, cr, cb, r, g, b;
        logic [SBW-1:0] sb;
    } exp_t;

    typedef struct {
        int r, g, b, y, cr, cb;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic rand_ready = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int clamp8(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    function automatic exp_t model(input int r, input int g, input int b, input int sb);
        exp_t e;
        int ys, cbs, crs;
        ys  =  77*r + 150*g +  29*b + 128;
        cbs = -43*r -  85*g + 128*b + 128;
        crs = 128*r - 107*g -  21*b + 128;
        e.y  = 8'(clamp8(ys >>> 8));
        e.cb = 8'(clamp8((cbs >>> 8) + 128));
        e.cr = 8'(clamp8((crs >>> 8) + 128));
        e.r  = 8'(r);
        e.g  = 8'(g);
        e.b  = 8'(b);
        e.sb = SBW'(sb);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) ready_in = 1'($urandom_range(0, 1));
    endtask

    // Presents a pixel and holds it until accepted; the expectation is queued at acceptance.
    task automatic send_pixel(input exp_t e);
        r_in = e.r; g_in = e.g; b_in = e.b; sideband_in = e.sb;
        valid_in = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (ready_out) begin
                exp_q.push_back(e);
                tick();
                return;
            end
            tick();
        end
        check("accept_timeout", ready_out, 1);
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        valid_in = 1'b0;
        while (exp_q.size() != 0 && t < 300) begin
            tick();
            t++;
        end
        check(name, exp_q.size(), 0);
    endtask

    // Every cycle with valid_out, the shown pixel must be the oldest outstanding one.
    always @(negedge clk) begin
        if (rst_n_in && valid_out) begin
            if (exp_q.size() == 0) begin
                check("stale_valid", valid_out, 0);
            end else begin
                mon_e = exp_q[0];
                check("pixel", {y_out, cr_out, cb_out, r_out, g_out, b_out, sideband_out},
                      {mon_e.y, mon_e.cr, mon_e.cb, mon_e.r, mon_e.g, mon_e.b, mon_e.sb});
                if (ready_in) begin
                    $display("OUT sb=%0h rgb=(%0d,%0d,%0d) y=%0d cr=%0d cb=%0d",
                             sideband_out, r_out, g_out, b_out, y_out, cr_out, cb_out);
                    exp_q.delete(0);
                end
            end
        end
    end

    vec_t tbl[6];
    int   pat[16];
    int   vo[16];
    int   cnt;
    exp_t e;

    initial begin
        tbl[0] = '{r:0,   g:0,   b:0,   y:0,   cr:128, cb:128};
        tbl[1] = '{r:255, g:255, b:255, y:255, cr:128, cb:128};
        tbl[2] = '{r:255, g:0,   b:0,   y:77,  cr:255, cb:85};
        tbl[3] = '{r:0,   g:255, b:0,   y:149, cr:21,  cb:43};
        tbl[4] = '{r:0,   g:0,   b:255, y:29,  cr:107, cb:255};
        tbl[5] = '{r:128, g:128, b:128, y:128, cr:128, cb:128};

        // Reset held with valid input: nothing gets in, everything reads 0.
        rst_n_in = 1'b0; ready_in = 1'b1; valid_in = 1'b1;
        r_in = 8'hAA; g_in = 8'h55; b_in = 8'hF0; sideband_in = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid", valid_out, 0);
        check("reset_data", {y_out, cr_out, cb_out, r_out, g_out, b_out, sideband_out}, 0);
        tick();
        valid_in = 1'b0;
        rst_n_in = 1'b1;
        tick();

        // Latency: valid_out appears on the third cycle after acceptance.
        send_pixel(model(10, 20, 30, 1));
        valid_in = 1'b0;
        @(negedge clk); check("latency_c1", valid_out, 0);
        tick();
        @(negedge clk); check("latency_c2", valid_out, 0);
        tick();
        @(negedge clk); check("latency_c3", valid_out, 1);
        tick();
        drain("drain_latency");

        // Stall: output held, new input refused while valid_out && !ready_in.
        ready_in = 1'b0;
        send_pixel(model(200, 100, 50, 2));
        valid_in = 1'b0;
        repeat (3) tick();
        r_in = 8'd1; g_in = 8'd2; b_in = 8'd3; sideband_in = SBW'(3); valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_ready", ready_out, 0);
            check("stall_valid", valid_out, 1);
            tick();
        end
        ready_in = 1'b1;
        send_pixel(model(1, 2, 3, 3));
        drain("drain_stall");

        // Colour points back to back, hand-computed expectations.
        for (int i = 0; i < 6; i++) begin
            e.r = 8'(tbl[i].r); e.g = 8'(tbl[i].g); e.b = 8'(tbl[i].b);
            e.y = 8'(tbl[i].y); e.cr = 8'(tbl[i].cr); e.cb = 8'(tbl[i].cb);
            e.sb = SBW'(100 + i);
            send_pixel(e);
        end
        drain("drain_table");

        // Random backpressure stream.
        rand_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send_pixel(model(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                             int'($urandom_range(0, 255)), i));
        end
        drain("drain_stream");
        rand_ready = 1'b0;
        ready_in = 1'b1;
        repeat (4) tick();

        // One-on two-off input pattern must reappear 3 cycles later.
        for (int c = 0; c < 16; c++) begin
            pat[c] = (c < 12 && (c % 3) == 0) ? 1 : 0;
            e = model(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 255)), 200 + c);
            r_in = e.r; g_in = e.g; b_in = e.b; sideband_in = e.sb;
            valid_in = pat[c][0];
            @(negedge clk);
            if (valid_in && ready_out) exp_q.push_back(e);
            vo[c] = int'(valid_out);
            tick();
        end
        for (int c = 0; c < 16; c++) begin
            check($sformatf("gap_pattern_c%0d", c), vo[c], (c >= 3) ? pat[c-3] : 0);
        end
        drain("drain_gap");

        // Asynchronous reset with three pixels in flight.
        for (int i = 0; i < 3; i++) send_pixel(model(50 + i, 60, 70, 300 + i));
        valid_in = 1'b0;
        #2;
        check("inflight_valid", valid_out, 1);
        rst_n_in = 1'b0;
        #1;
        check("async_valid", valid_out, 0);
        check("async_data", {y_out, cr_out, cb_out, r_out, g_out, b_out, sideband_out}, 0);
        exp_q.delete();
        tick();
        tick();
        rst_n_in = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (valid_out) cnt++;
            tick();
        end
        check("post_reset_stale", cnt, 0);

        // Sweep: every grey level (chroma exactly 128) then random pixels.
        for (int v = 0; v < 256; v++) begin
            e = model(v, v, v, v);
            e.cr = 8'd128;
            e.cb = 8'd128;
            send_pixel(e);
        end
        for (int i = 0; i < 2000; i++) begin
            send_pixel(model(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                             int'($urandom_range(0, 255)), 1000 + i));
        end
        drain("drain_sweep");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
